// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-wide memory port sequencer: access sizes,
// sequencer states and the IO address marker.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    LsByte = 2'd0,
    LsHalf = 2'd1,
    LsWord = 2'd2
  } ls_size_bus_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam logic [1:0] IoAddrHiDefault = 2'b11;

  // Number of byte transactions for an access; the unused encoding is treated as a word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (ls_size_bus_t'(size))
      LsByte:  return 3'd1;
      LsHalf:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the single byte-wide RAM/IO port between fetch and load/store,
// splitting each access into byte transactions and reassembling read data.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IoAddrHi = IoAddrHiDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr_i,
  input  logic        IfEn_i,
  input  logic [31:0] IfAddr_i,
  output logic        IfDone_o,
  output logic [31:0] IfData_o,
  input  logic        LsEn_i,
  input  logic        LsWr_i,
  input  logic [1:0]  LsSize_i,
  input  logic [31:0] LsAddr_i,
  input  logic [31:0] LsData_i,
  output logic        LsDone_o,
  output logic [31:0] LsData_o,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  mem_state_t  state, state_nxt;
  logic        owner_ls;
  logic        is_store;
  logic [2:0]  cnt;
  logic [2:0]  nbytes;
  logic [31:0] base;
  logic [31:0] asm_data;
  logic        accept_ls, accept_if;
  logic        io_stall;
  logic [2:0]  cnt_inc;
  logic [1:0]  rd_idx;
  logic [1:0]  wr_idx;

  assign cnt_inc = cnt + 3'd1;
  // Read data lags its address by a cycle, so the byte landing now belongs to cnt-1.
  assign rd_idx  = cnt[1:0] - 2'd1;
  assign wr_idx  = cnt_inc[1:0];
  assign io_stall = LsEn_i && LsWr_i && (LsAddr_i[17:16] == IoAddrHi) && io_buffer_full;

  assign IfData_o = asm_data;
  assign LsData_o = asm_data;

  always_comb begin
    state_nxt = state;
    accept_ls = 1'b0;
    accept_if = 1'b0;
    IfDone_o  = 1'b0;
    LsDone_o  = 1'b0;
    mem_wr    = 1'b0;
    case (state)
      IDLE: begin
        // A stalled IO store still blocks fetch; flushed loads and fetches are refused outright.
        if (LsEn_i) begin
          if (!io_stall && (LsWr_i || !clr_i)) begin
            accept_ls = 1'b1;
            state_nxt = LsWr_i ? WR : RD;
          end
        end else if (IfEn_i && !clr_i) begin
          accept_if = 1'b1;
          state_nxt = RD;
        end
      end
      RD: begin
        if (clr_i)
          state_nxt = IDLE;
        else if (cnt == nbytes)
          state_nxt = DONE;
      end
      WR: begin
        mem_wr = rdy;
        if (cnt_inc == nbytes)
          state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        if (owner_ls)
          LsDone_o = is_store || !clr_i;
        else
          IfDone_o = !clr_i;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner_ls <= 1'b0;
      is_store <= 1'b0;
      cnt      <= '0;
      nbytes   <= '0;
      base     <= '0;
      asm_data <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
    end else if (rdy) begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept_ls) begin
            owner_ls <= 1'b1;
            is_store <= LsWr_i;
            nbytes   <= size_to_bytes(LsSize_i);
            base     <= LsAddr_i;
            cnt      <= '0;
            asm_data <= '0;
            mem_a    <= LsAddr_i;
            if (LsWr_i)
              mem_dout <= LsData_i[7:0];
          end else if (accept_if) begin
            owner_ls <= 1'b0;
            is_store <= 1'b0;
            nbytes   <= 3'd4;
            base     <= IfAddr_i;
            cnt      <= '0;
            asm_data <= '0;
            mem_a    <= IfAddr_i;
          end
        end
        RD: begin
          cnt <= cnt_inc;
          if (cnt != 3'd0)
            asm_data[{rd_idx, 3'b000} +: 8] <= mem_din;
          if (cnt_inc < nbytes)
            mem_a <= base + {29'd0, cnt_inc};
        end
        WR: begin
          cnt <= cnt_inc;
          if (cnt_inc < nbytes) begin
            mem_a    <= base + {29'd0, cnt_inc};
            mem_dout <= LsData_i[{wr_idx, 3'b000} +: 8];
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a table of single transactions against a
// byte RAM model, then hand-written contention, flush, stall, freeze and reset sequences.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, clr_i;
  logic        IfEn_i, LsEn_i, LsWr_i;
  logic [1:0]  LsSize_i;
  logic [31:0] IfAddr_i, LsAddr_i, LsData_i;
  logic        IfDone_o, LsDone_o;
  logic [31:0] IfData_o, LsData_o;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  logic [7:0]  ram [0:65535];
  logic        init_ram;
  int          wr_count;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        ls;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_edge;
  } vec_t;

  vec_t vecs [10];

  mem_ctrl #(.IoAddrHi(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr_i(clr_i),
    .IfEn_i(IfEn_i), .IfAddr_i(IfAddr_i), .IfDone_o(IfDone_o), .IfData_o(IfData_o),
    .LsEn_i(LsEn_i), .LsWr_i(LsWr_i), .LsSize_i(LsSize_i), .LsAddr_i(LsAddr_i),
    .LsData_i(LsData_i), .LsDone_o(LsDone_o), .LsData_o(LsData_o),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: one-cycle read latency, frozen along with the controller when rdy is low.
  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
      ram[16'h0100] <= 8'h13; ram[16'h0101] <= 8'h05;
      ram[16'h0010] <= 8'h80;
      ram[16'h0200] <= 8'h34; ram[16'h0201] <= 8'h12;
      ram[16'h0203] <= 8'hAA; ram[16'h0204] <= 8'hBB;
      ram[16'h0205] <= 8'hCC; ram[16'h0206] <= 8'hDD;
      ram[16'hFFFE] <= 8'h01; ram[16'hFFFF] <= 8'h02;
      ram[16'h0000] <= 8'h03; ram[16'h0001] <= 8'h04;
      wr_count <= 0;
      mem_din  <= 8'h00;
    end else begin
      if (mem_wr) begin
        ram[mem_a[15:0]] <= mem_dout;
        wr_count <= wr_count + 1;
      end
      if (rdy) mem_din <= ram[mem_a[15:0]];
    end
  end

  function automatic logic [7:0] byteOf(input logic [31:0] w, input int k);
    return w[8*k +: 8];
  endfunction

  function automatic logic [7:0] ramAt(input logic [31:0] a);
    return ram[a[15:0]];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Waits (bounded) for either Done; edge_n counts posedges after the request edge.
  task automatic waitAnyDone(output int edge_n, output logic was_ls, output logic [31:0] data);
    edge_n = -1;
    was_ls = 1'b0;
    data   = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (IfDone_o || LsDone_o) begin
        edge_n = i;
        was_ls = LsDone_o;
        data   = LsDone_o ? LsData_o : IfData_o;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int          n;
    int          edge_n;
    logic        was_ls;
    logic [31:0] data;
    n = !v.ls ? 4 : (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    if (v.ls) begin
      LsEn_i = 1'b1; LsWr_i = v.wr; LsSize_i = v.size; LsAddr_i = v.addr; LsData_i = v.wdata;
    end else begin
      IfEn_i = 1'b1; IfAddr_i = v.addr;
    end
    edge_n = -1; was_ls = 1'b0; data = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < n) begin
        checkOutput($sformatf("v%0d mem_a k=%0d", idx, i), mem_a, v.addr + 32'(i));
        checkOutput($sformatf("v%0d mem_wr k=%0d", idx, i), 32'(mem_wr), 32'(v.ls && v.wr));
        if (v.ls && v.wr)
          checkOutput($sformatf("v%0d mem_dout k=%0d", idx, i), 32'(mem_dout), 32'(byteOf(v.wdata, i)));
      end
      if (IfDone_o || LsDone_o) begin
        edge_n = i;
        was_ls = LsDone_o;
        data   = LsDone_o ? LsData_o : IfData_o;
        break;
      end
    end
    LsEn_i = 1'b0;
    IfEn_i = 1'b0;
    checkOutput($sformatf("v%0d owner", idx), 32'(was_ls), 32'(v.ls));
    checkOutput($sformatf("v%0d done edge", idx), 32'(edge_n), 32'(v.exp_edge));
    if (v.ls && v.wr) begin
      for (int k = 0; k < n; k++)
        checkOutput($sformatf("v%0d ram byte %0d", idx, k), 32'(ramAt(v.addr + 32'(k))),
                    32'(byteOf(v.exp_data, k)));
      checkOutput($sformatf("v%0d ram guard", idx), 32'(ramAt(v.addr + 32'(n))), 32'h0);
    end else begin
      checkOutput($sformatf("v%0d data", idx), data, v.exp_data);
    end
    @(negedge clk);
    checkOutput($sformatf("v%0d done width", idx), {30'd0, IfDone_o, LsDone_o}, 32'h0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int          e;
    logic        w;
    logic [31:0] d;
    int          w0;
    int          seen;

    vecs[0] = '{ls:1'b0, wr:1'b0, size:2'd2, addr:32'h0000_0100, wdata:32'h0, exp_data:32'h0000_0513, exp_edge:5};
    vecs[1] = '{ls:1'b1, wr:1'b0, size:2'd0, addr:32'h0000_0010, wdata:32'h0, exp_data:32'h0000_0080, exp_edge:2};
    vecs[2] = '{ls:1'b1, wr:1'b0, size:2'd1, addr:32'h0000_0200, wdata:32'h0, exp_data:32'h0000_1234, exp_edge:3};
    vecs[3] = '{ls:1'b1, wr:1'b0, size:2'd2, addr:32'h0000_0203, wdata:32'h0, exp_data:32'hDDCC_BBAA, exp_edge:5};
    vecs[4] = '{ls:1'b1, wr:1'b1, size:2'd1, addr:32'h0000_2002, wdata:32'hDEAD_BEEF, exp_data:32'h0000_BEEF, exp_edge:2};
    vecs[5] = '{ls:1'b1, wr:1'b1, size:2'd2, addr:32'h0000_3000, wdata:32'h1122_3344, exp_data:32'h1122_3344, exp_edge:4};
    vecs[6] = '{ls:1'b1, wr:1'b1, size:2'd0, addr:32'h0000_4000, wdata:32'hFFFF_FF5A, exp_data:32'h0000_005A, exp_edge:1};
    vecs[7] = '{ls:1'b1, wr:1'b0, size:2'd1, addr:32'h0000_2002, wdata:32'h0, exp_data:32'h0000_BEEF, exp_edge:3};
    vecs[8] = '{ls:1'b1, wr:1'b0, size:2'd0, addr:32'h0000_3003, wdata:32'h0, exp_data:32'h0000_0011, exp_edge:2};
    vecs[9] = '{ls:1'b0, wr:1'b0, size:2'd2, addr:32'hFFFF_FFFE, wdata:32'h0, exp_data:32'h0403_0201, exp_edge:5};

    rst = 1'b1; rdy = 1'b1; clr_i = 1'b0; init_ram = 1'b1;
    IfEn_i = 1'b0; LsEn_i = 1'b0; LsWr_i = 1'b0; LsSize_i = 2'd0;
    IfAddr_i = '0; LsAddr_i = '0; LsData_i = '0; io_buffer_full = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset IfDone", 32'(IfDone_o), 32'h0);
    checkOutput("reset LsDone", 32'(LsDone_o), 32'h0);
    checkOutput("reset IfData", IfData_o, 32'h0);
    checkOutput("reset LsData", LsData_o, 32'h0);
    checkOutput("reset mem_a", mem_a, 32'h0);
    checkOutput("reset mem_dout", 32'(mem_dout), 32'h0);
    checkOutput("reset mem_wr", 32'(mem_wr), 32'h0);
    rst = 1'b0; init_ram = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

    // Contention: load/store wins, fetch follows once the port is free again.
    IfEn_i = 1'b1; IfAddr_i = 32'h100;
    LsEn_i = 1'b1; LsWr_i = 1'b0; LsSize_i = 2'd0; LsAddr_i = 32'h10;
    waitAnyDone(e, w, d);
    LsEn_i = 1'b0;
    checkOutput("contend first owner", 32'(w), 32'h1);
    checkOutput("contend first edge", 32'(e), 32'd2);
    checkOutput("contend first data", d, 32'h0000_0080);
    waitAnyDone(e, w, d);
    IfEn_i = 1'b0;
    checkOutput("contend second owner", 32'(w), 32'h0);
    checkOutput("contend second edge", 32'(e), 32'd6);
    checkOutput("contend second data", d, 32'h0000_0513);
    @(negedge clk);

    // Flushed word load: no Done, controller back in IDLE.
    LsEn_i = 1'b1; LsWr_i = 1'b0; LsSize_i = 2'd2; LsAddr_i = 32'h203;
    repeat (3) @(negedge clk);
    clr_i = 1'b1; LsEn_i = 1'b0;
    @(negedge clk);
    clr_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (LsDone_o || IfDone_o) seen++;
    end
    checkOutput("flush load no done", 32'(seen), 32'h0);
    IfEn_i = 1'b1; IfAddr_i = 32'h100;
    waitAnyDone(e, w, d);
    IfEn_i = 1'b0;
    checkOutput("flush load then fetch edge", 32'(e), 32'd5);
    checkOutput("flush load then fetch data", d, 32'h0000_0513);
    @(negedge clk);

    // Load presented together with a flush is ignored for that cycle only.
    LsEn_i = 1'b1; LsWr_i = 1'b0; LsSize_i = 2'd0; LsAddr_i = 32'h10; clr_i = 1'b1;
    fork begin @(negedge clk); clr_i = 1'b0; end join_none
    waitAnyDone(e, w, d);
    LsEn_i = 1'b0;
    checkOutput("clr pending load edge", 32'(e), 32'd3);
    checkOutput("clr pending load data", d, 32'h0000_0080);
    @(negedge clk);

    // Flush landing in the DONE cycle of a load suppresses its pulse.
    LsEn_i = 1'b1; LsWr_i = 1'b0; LsSize_i = 2'd2; LsAddr_i = 32'h203;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("done cycle pulse", 32'(LsDone_o), 32'h1);
    checkOutput("done cycle data", LsData_o, 32'hDDCC_BBAA);
    clr_i = 1'b1; LsEn_i = 1'b0;
    #1;
    checkOutput("done cycle flushed", 32'(LsDone_o), 32'h0);
    @(negedge clk);
    clr_i = 1'b0;
    @(negedge clk);

    // Flushed word store still writes every byte and reports Done.
    w0 = wr_count;
    LsEn_i = 1'b1; LsWr_i = 1'b1; LsSize_i = 2'd2; LsAddr_i = 32'h5000; LsData_i = 32'hCAFE_F00D;
    fork begin repeat (3) @(negedge clk); clr_i = 1'b1; @(negedge clk); clr_i = 1'b0; end join_none
    waitAnyDone(e, w, d);
    LsEn_i = 1'b0;
    checkOutput("flush store owner", 32'(w), 32'h1);
    checkOutput("flush store edge", 32'(e), 32'd4);
    checkOutput("flush store writes", 32'(wr_count - w0), 32'd4);
    checkOutput("flush store ram", {ramAt(32'h5003), ramAt(32'h5002), ramAt(32'h5001), ramAt(32'h5000)},
                32'hCAFE_F00D);
    @(negedge clk);

    // IO store stall: nothing starts while the buffer is full, fetch included.
    w0 = wr_count;
    IfEn_i = 1'b1; IfAddr_i = 32'h100;
    LsEn_i = 1'b1; LsWr_i = 1'b1; LsSize_i = 2'd0; LsAddr_i = 32'h3_0000; LsData_i = 32'h77;
    io_buffer_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("io stall mem_wr c%0d", i), 32'(mem_wr), 32'h0);
      checkOutput($sformatf("io stall mem_a c%0d", i), mem_a, 32'h5003);
    end
    io_buffer_full = 1'b0;
    @(negedge clk);
    checkOutput("io write mem_wr", 32'(mem_wr), 32'h1);
    checkOutput("io write mem_a", mem_a, 32'h3_0000);
    checkOutput("io write mem_dout", 32'(mem_dout), 32'h77);
    waitAnyDone(e, w, d);
    LsEn_i = 1'b0; IfEn_i = 1'b0;
    checkOutput("io store owner", 32'(w), 32'h1);
    checkOutput("io store edge", 32'(e), 32'd0);
    checkOutput("io store writes", 32'(wr_count - w0), 32'd1);
    @(negedge clk);

    // rdy low for two edges in the middle of a word store.
    w0 = wr_count;
    LsEn_i = 1'b1; LsWr_i = 1'b1; LsSize_i = 2'd2; LsAddr_i = 32'h6000; LsData_i = 32'h0102_0304;
    repeat (2) @(negedge clk);
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("freeze mem_wr c%0d", i), 32'(mem_wr), 32'h0);
      checkOutput($sformatf("freeze mem_a c%0d", i), mem_a, 32'h6001);
      checkOutput($sformatf("freeze mem_dout c%0d", i), 32'(mem_dout), 32'h03);
    end
    rdy = 1'b1;
    waitAnyDone(e, w, d);
    LsEn_i = 1'b0;
    checkOutput("freeze done edge", 32'(e), 32'd2);
    checkOutput("freeze writes", 32'(wr_count - w0), 32'd4);
    checkOutput("freeze ram", {ramAt(32'h6003), ramAt(32'h6002), ramAt(32'h6001), ramAt(32'h6000)},
                32'h0102_0304);
    @(negedge clk);

    // Reset in the middle of a store: no further writes and no Done.
    LsEn_i = 1'b1; LsWr_i = 1'b1; LsSize_i = 2'd2; LsAddr_i = 32'h7000; LsData_i = 32'hAABB_CCDD;
    repeat (2) @(negedge clk);
    rst = 1'b1; LsEn_i = 1'b0;
    @(negedge clk);
    w0 = wr_count;
    checkOutput("midreset mem_wr", 32'(mem_wr), 32'h0);
    checkOutput("midreset mem_a", mem_a, 32'h0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (LsDone_o || IfDone_o || mem_wr) seen++;
    end
    checkOutput("midreset quiet", 32'(seen), 32'h0);
    checkOutput("midreset writes", 32'(wr_count - w0), 32'h0);
    checkOutput("midreset ram tail", 32'(ramAt(32'h7003)), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
